mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_if.sv
// mem_port_if: bundle of the three requester ports (data, fetch, loader)
// and the single-port memory drive around mem_port_arbiter.
//   d_*   : data port (MEM stage), read/write
//   i_*   : instruction fetch port, read-only
//   l_*   : program loader port, read/write
//   mem_* : single-port memory; mem_rdata is valid one cycle after a read
// Modports: slave = arbiter side, master = requesters + memory side.
interface mem_port_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;

  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;

  logic          l_req, l_we, l_gnt, l_rvalid;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata, l_rdata;

  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  modport slave (
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  l_req, l_we, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output l_req, l_we, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the data port,
// the instruction fetch port and the program loader.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   halt            : pipeline halted (no data/fetch grants once HALTED)
//   load_mode       : loader owns the memory exclusively (LOAD state)
//   bus (slave)     : requester ports and memory drive, see mem_port_if
// Grants are combinational from the current requests and the registered
// state; reads return exactly one cycle later to the registered owner.
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        load_mode,
  mem_port_if.slave   bus
);

  typedef enum logic [1:0] {RUN = 2'd0, LOAD = 2'd1, HALTED = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_D, OWN_I, OWN_L} own_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t     state, state_nxt;
  own_t       owner, owner_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       d_gnt, i_gnt, l_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      owner      <= OWN_NONE;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Mode changes land one cycle after the inputs move; load_mode wins.
  always_comb begin
    state_nxt = RUN;
    if (load_mode) state_nxt = LOAD;
    else begin
      case (state)
        RUN:     state_nxt = halt ? HALTED : RUN;
        LOAD:    state_nxt = RUN;
        HALTED:  state_nxt = halt ? HALTED : RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // Grants follow the registered state only, so in the cycle halt or
  // load_mode changes the old state's arbitration still applies.
  // Gated by rst_n so every output is quiet while reset is held.
  always_comb begin
    d_gnt = 1'b0;
    i_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (bus.i_req && (starve_cnt == LIM || !bus.d_req)) i_gnt = 1'b1;
          else if (bus.d_req)                                d_gnt = 1'b1;
        end
        LOAD:    l_gnt = bus.l_req;
        default: ;
      endcase
    end
  end

  // Counts consecutive fetch denials; saturates so fetch keeps priority
  // until it is actually served.
  always_comb begin
    starve_nxt = 4'd0;
    if (state != LOAD && bus.i_req && !i_gnt)
      starve_nxt = (starve_cnt >= LIM) ? LIM : starve_cnt + 4'd1;
  end

  // Only reads claim the return slot; writes complete silently.
  always_comb begin
    owner_nxt = OWN_NONE;
    if (d_gnt && !bus.d_we)      owner_nxt = OWN_D;
    else if (i_gnt)              owner_nxt = OWN_I;
    else if (l_gnt && !bus.l_we) owner_nxt = OWN_L;
  end

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (d_gnt) begin
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end else if (i_gnt) begin
      bus.mem_addr  = bus.i_addr;
    end else if (l_gnt) begin
      bus.mem_we    = bus.l_we;
      bus.mem_addr  = bus.l_addr;
      bus.mem_wdata = bus.l_wdata;
    end
  end

  assign bus.mem_en   = d_gnt | i_gnt | l_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.i_gnt    = i_gnt;
  assign bus.l_gnt    = l_gnt;

  assign bus.d_rvalid = (owner == OWN_D);
  assign bus.i_rvalid = (owner == OWN_I);
  assign bus.l_rvalid = (owner == OWN_L);
  assign bus.d_rdata  = (owner == OWN_D) ? bus.mem_rdata : '0;
  assign bus.i_rdata  = (owner == OWN_I) ? bus.mem_rdata : '0;
  assign bus.l_rdata  = (owner == OWN_L) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by randomized traffic.
// A reference model predicts each cycle's grant/memory drive and each read
// response; a monitor on the falling edge pops and compares.
module tb_mem_port_arbiter;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clk = 1'b0, rst_n = 1'b0, halt = 1'b0, load_mode = 1'b0;
  always #5 clk = ~clk;

  mem_port_if #(.AW(AW), .DW(DW)) bus();

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .load_mode(load_mode), .bus(bus.slave)
  );

  typedef struct {
    logic rst, halt, lm;
    logic d_req, d_we; logic [AW-1:0] d_addr; logic [DW-1:0] d_wdata;
    logic i_req;       logic [AW-1:0] i_addr;
    logic l_req, l_we; logic [AW-1:0] l_addr; logic [DW-1:0] l_wdata;
  } stim_t;

  typedef struct packed {
    logic d, i, l, en, we; logic [AW-1:0] addr; logic [DW-1:0] wdata;
  } gexp_t;

  typedef struct { int due; int who; logic [DW-1:0] data; } rsp_t;

  gexp_t exp_q[$];
  rsp_t  rsp_q[$];
  int    n_cmp = 0, n_bad = 0, cyc = 0;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] env_mem [0:(1<<AW)-1];

  // reference model state: mode 0=run 1=load 2=halted, fetch denial streak
  int mode = 0, denials = 0;

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 15));
  endfunction

  // One clock: drive inputs after the edge, predict the cycle, advance model.
  task automatic step(input stim_t s, output int who);
    gexp_t g;
    rsp_t  r;
    @(posedge clk); #1;
    rst_n = s.rst; halt = s.halt; load_mode = s.lm;
    bus.d_req = s.d_req; bus.d_we = s.d_we; bus.d_addr = s.d_addr; bus.d_wdata = s.d_wdata;
    bus.i_req = s.i_req; bus.i_addr = s.i_addr;
    bus.l_req = s.l_req; bus.l_we = s.l_we; bus.l_addr = s.l_addr; bus.l_wdata = s.l_wdata;
    cyc++;
    g = '0; who = 0;
    if (!s.rst) begin
      mode = 0; denials = 0;
      rsp_q.delete();
      exp_q.push_back(g);
      return;
    end
    case (mode)
      1: if (s.l_req) who = 3;
      2: who = 0;
      default: begin
        if (s.d_req && s.i_req) who = (denials >= LIM) ? 2 : 1;
        else if (s.d_req)       who = 1;
        else if (s.i_req)       who = 2;
      end
    endcase
    case (who)
      1: begin g.d = 1; g.we = s.d_we; g.addr = s.d_addr; g.wdata = s.d_wdata; end
      2: begin g.i = 1; g.addr = s.i_addr; end
      3: begin g.l = 1; g.we = s.l_we; g.addr = s.l_addr; g.wdata = s.l_wdata; end
      default: ;
    endcase
    g.en = (who != 0);
    if (g.en) begin
      if (g.we) ref_mem[g.addr] = g.wdata;
      else begin
        r.due = cyc + 1; r.who = who; r.data = ref_mem[g.addr];
        rsp_q.push_back(r);
      end
    end
    exp_q.push_back(g);
    if (mode == 1)                  denials = 0;
    else if (s.i_req && who != 2)   denials = (denials < LIM) ? denials + 1 : LIM;
    else                            denials = 0;
    mode = s.lm ? 1 : (mode == 1 ? 0 : (s.halt ? 2 : 0));
  endtask

  // Memory environment: one-cycle read latency, garbage when not reading.
  initial begin
    logic [DW-1:0] nx;
    logic          hv;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      hv = 1'b0; nx = '0;
      if (bus.mem_en) begin
        if (bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
        else begin nx = env_mem[bus.mem_addr]; hv = 1'b1; end
      end
      @(posedge clk); #1;
      bus.mem_rdata = hv ? nx : $urandom;
    end
  end

  // Monitor
  gexp_t ge, ga;
  rsp_t  rr;
  logic [3+3*DW-1:0] re, ra;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        ge = exp_q.pop_front();
        ga = {bus.d_gnt, bus.i_gnt, bus.l_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};
        n_cmp++;
        if (ga !== ge) begin
          n_bad++;
          $display("FAIL grant cyc=%0d got %h expected %h", cyc, ga, ge);
        end
        re = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
          rr = rsp_q.pop_front();
          case (rr.who)
            1: re = {3'b100, rr.data, {DW{1'b0}}, {DW{1'b0}}};
            2: re = {3'b010, {DW{1'b0}}, rr.data, {DW{1'b0}}};
            default: re = {3'b001, {DW{1'b0}}, {DW{1'b0}}, rr.data};
          endcase
        end
        ra = {bus.d_rvalid, bus.i_rvalid, bus.l_rvalid, bus.d_rdata, bus.i_rdata, bus.l_rdata};
        n_cmp++;
        if (ra !== re) begin
          n_bad++;
          $display("FAIL resp cyc=%0d got %h expected %h", cyc, ra, re);
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    who;
    logic [DW-1:0] v;
    for (int k = 0; k < (1 << AW); k++) begin
      v = $urandom; ref_mem[k] = v; env_mem[k] = v;
    end
    ref_mem[5] = 32'h12345678; env_mem[5] = 32'h12345678;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.i_req = 0; bus.i_addr = '0;
    bus.l_req = 0; bus.l_we = 0; bus.l_addr = '0; bus.l_wdata = '0;
    s = '{default: '0};

    // reset held with traffic present: everything must stay quiet
    s.d_req = 1; s.i_req = 1; s.l_req = 1;
    repeat (3) step(s, who);
    s = '{default: '0}; s.rst = 1;

    // fetch right after reset release, one-cycle read return
    s.i_req = 1; s.i_addr = 5; step(s, who);
    s.i_req = 0; step(s, who);

    // data and fetch both held: fetch wins every (LIM+1)th cycle
    s.d_req = 1; s.d_addr = 10'h020; s.i_req = 1; s.i_addr = 10'h021;
    repeat (12) step(s, who);
    s.d_req = 0; s.i_req = 0; step(s, who);

    // write at the top address, then read it back
    s.d_req = 1; s.d_we = 1; s.d_addr = 10'h3FF; s.d_wdata = 32'hA5A5A5A5; step(s, who);
    s.d_we = 0; step(s, who);
    s.d_req = 0; step(s, who);

    // load mode takes over with everyone requesting, then releases
    s.d_req = 1; s.i_req = 1; s.l_req = 1; s.l_addr = 10'h3FF; s.lm = 1;
    repeat (4) step(s, who);
    s.lm = 0; repeat (3) step(s, who);
    s = '{default: '0}; s.rst = 1;

    // halt right after a granted data read
    s.d_req = 1; s.d_addr = 10'h005; step(s, who);
    s.halt = 1; s.d_addr = 10'h006; repeat (4) step(s, who);
    s.halt = 0; repeat (3) step(s, who);

    // reset pulse with a read outstanding
    s.d_req = 1; s.d_addr = 10'h3FF; step(s, who);
    s.rst = 0; s.d_req = 0; repeat (2) step(s, who);
    s.rst = 1; repeat (2) step(s, who);

    // randomized traffic; requests stay stable until granted
    s = '{default: '0}; s.rst = 1;
    for (int n = 0; n < 800; n++) begin
      if (!s.d_req && $urandom_range(0, 1) == 1) begin
        s.d_req = 1; s.d_we = 1'($urandom_range(0, 1)); s.d_addr = rnd_addr(); s.d_wdata = $urandom;
      end
      if (!s.i_req && $urandom_range(0, 1) == 1) begin
        s.i_req = 1; s.i_addr = rnd_addr();
      end
      if (!s.l_req && $urandom_range(0, 1) == 1) begin
        s.l_req = 1; s.l_we = 1'($urandom_range(0, 1)); s.l_addr = rnd_addr(); s.l_wdata = $urandom;
      end
      if ($urandom_range(0, 15) == 0) s.halt = ~s.halt;
      if ($urandom_range(0, 23) == 0) s.lm = ~s.lm;
      s.rst = ($urandom_range(0, 149) != 0);
      step(s, who);
      case (who)
        1: s.d_req = 0;
        2: s.i_req = 0;
        3: s.l_req = 0;
        default: ;
      endcase
    end
    s = '{default: '0}; s.rst = 1;
    repeat (3) step(s, who);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
